// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns PC/IR/TR and runs a req/ack memory read with timeout.
// Fetch done two cycles after the command when ack is immediate; commands arriving while busy are dropped.
module fetch_unit #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_ir,
  input  logic              fetch_tr,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] tr,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   tr_q, tr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_req_q, mem_req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fault_q, fault_d;
  logic                sel_tr_q, sel_tr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    tr_d       = tr_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fault_d    = fault_q;
    sel_tr_d   = sel_tr_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (jump_en) begin
          pc_d   = jump_addr;
          done_d = 1'b1;
        end else if (fetch_ir || fetch_tr) begin
          sel_tr_d   = !fetch_ir;
          mem_addr_d = pc_q;
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = REQ;
        end
      end
      default: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          if (sel_tr_q) tr_d = mem_rdata;
          else          ir_d = mem_rdata;
          pc_d      = pc_q + ADDR_W'(1);
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          fault_d   = 1'b1;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      tr_q       <= '0;
      mem_addr_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      sel_tr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      tr_q       <= tr_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      sel_tr_q   <= sel_tr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign fault    = fault_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign tr       = tr_q;
  assign mem_addr = mem_addr_q;
  assign mem_req  = mem_req_q;
  assign opcode   = ir_q[DATA_W-1 -: 4];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then randomized traffic vs a transaction model.
module tb_fetch_unit;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              fetch_ir = 1'b0, fetch_tr = 1'b0, jump_en = 1'b0;
  logic [ADDR_W-1:0] jump_addr = '0;
  logic              busy, done, fault, mem_req;
  logic [ADDR_W-1:0] pc, mem_addr;
  logic [DATA_W-1:0] ir, tr, mem_rdata;
  logic [3:0]        opcode;
  logic              mem_ack = 1'b0;

  logic [DATA_W-1:0] mem [256];

  fetch_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(8'h00), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .fetch_ir(fetch_ir), .fetch_tr(fetch_tr), .jump_en(jump_en),
    .jump_addr(jump_addr), .busy(busy), .done(done), .fault(fault), .pc(pc), .ir(ir), .tr(tr),
    .opcode(opcode), .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory responder: data always reflects the addressed word.
  assign mem_rdata = mem[mem_addr];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an outstanding read is just "how many cycles it has waited".
  bit              m_pending;
  bit              m_to_tr;
  int              m_waited;
  logic [7:0]      m_pc, m_ir, m_tr, m_addr;
  bit              m_done, m_fault;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending = 0; m_to_tr = 0; m_waited = 0;
      m_pc = 8'h00; m_ir = 8'h00; m_tr = 8'h00; m_addr = 8'h00;
      m_done = 0; m_fault = 0;
    end else begin
      m_done = 0;
      if (m_pending) begin
        m_waited = m_waited + 1;
        if (mem_ack) begin
          if (m_to_tr) m_tr = mem[m_addr];
          else         m_ir = mem[m_addr];
          m_pc = 8'((int'(m_pc) + 1) % 256);
          m_pending = 0;
          m_done = 1;
        end else if (m_waited == TIMEOUT) begin
          m_fault = 1;
          m_pending = 0;
          m_done = 1;
        end
      end else if (jump_en) begin
        m_pc = jump_addr;
        m_done = 1;
      end else if (fetch_ir || fetch_tr) begin
        m_pending = 1;
        m_to_tr = !fetch_ir;
        m_addr = m_pc;
        m_waited = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", busy, m_pending);
      chk("m_mem_req", mem_req, m_pending);
      chk("m_done", done, m_done);
      chk("m_fault", fault, m_fault);
      chk("m_pc", pc, m_pc);
      chk("m_ir", ir, m_ir);
      chk("m_tr", tr, m_tr);
      chk("m_opcode", opcode, m_ir[7:4]);
      chk("m_mem_addr", mem_addr, m_addr);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  int ack_pct;
  int r;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'hA5;
    mem[8'h01] = 8'h3C;
    mem[8'hFF] = 8'h12;

    #1 rst = 1'b1;
    tick(); tick();
    chk("rst_pc", pc, 8'h00);
    chk("rst_ir", ir, 8'h00);
    chk("rst_tr", tr, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    rst = 1'b0;
    chk_en = 1'b1;

    // Fetch IR, immediate ack.
    fetch_ir = 1'b1;
    tick();
    chk("f1_busy", busy, 1'b1);
    chk("f1_addr", mem_addr, 8'h00);
    chk("f1_done_early", done, 1'b0);
    fetch_ir = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("f1_done", done, 1'b1);
    chk("f1_busy_low", busy, 1'b0);
    chk("f1_ir", ir, 8'hA5);
    chk("f1_opcode", opcode, 4'hA);
    chk("f1_pc", pc, 8'h01);

    // Fetch TR, ack in the fourth REQ cycle.
    fetch_tr = 1'b1;
    tick();
    fetch_tr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("f2_addr_hold", mem_addr, 8'h01);
      chk("f2_req_hold", mem_req, 1'b1);
      chk("f2_no_done", done, 1'b0);
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("f2_done", done, 1'b1);
    chk("f2_tr", tr, 8'h3C);
    chk("f2_ir_kept", ir, 8'hA5);
    chk("f2_pc", pc, 8'h02);

    // All three commands at once: only the jump runs.
    jump_en = 1'b1; jump_addr = 8'hFF; fetch_ir = 1'b1; fetch_tr = 1'b1;
    tick();
    jump_en = 1'b0; fetch_tr = 1'b0;
    chk("j_pc", pc, 8'hFF);
    chk("j_done", done, 1'b1);
    chk("j_busy", busy, 1'b0);
    // fetch_ir held across the done cycle is accepted, then re-issued while busy.
    tick();
    chk("j_fetch_busy", busy, 1'b1);
    chk("j_fetch_addr", mem_addr, 8'hFF);
    jump_en = 1'b1; jump_addr = 8'h40;
    tick();
    fetch_ir = 1'b0; jump_en = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("w_ir", ir, 8'h12);
    chk("w_pc_wrap", pc, 8'h00);
    chk("w_done", done, 1'b1);
    tick();
    chk("w_single_done", done, 1'b0);
    chk("w_not_queued", busy, 1'b0);

    // Timeout.
    fetch_ir = 1'b1;
    tick();
    fetch_ir = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      chk("to_wait_fault", fault, 1'b0);
      chk("to_wait_req", mem_req, 1'b1);
    end
    tick();
    chk("to_fault", fault, 1'b1);
    chk("to_done", done, 1'b1);
    chk("to_req_drop", mem_req, 1'b0);
    chk("to_ir", ir, 8'h12);
    chk("to_pc", pc, 8'h00);
    fetch_tr = 1'b1;
    tick();
    fetch_tr = 1'b0; mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("after_to_tr", tr, 8'hA5);
    chk("after_to_pc", pc, 8'h01);
    chk("after_to_fault", fault, 1'b1);

    // Reset in REQ, then a stale ack.
    fetch_ir = 1'b1;
    tick();
    fetch_ir = 1'b0;
    chk("rr_req", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rr_req_drop", mem_req, 1'b0);
    chk("rr_pc", pc, 8'h00);
    chk("rr_fault_clr", fault, 1'b0);
    tick();
    rst = 1'b0; mem_ack = 1'b1;
    tick(); tick();
    mem_ack = 1'b0;
    chk("rr_ir", ir, 8'h00);
    chk("rr_busy", busy, 1'b0);
    chk("rr_done", done, 1'b0);

    // Randomized traffic, segments of varying memory responsiveness.
    for (int seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 3);
      ack_pct = (r == 0) ? 0 : (r == 1) ? 20 : (r == 2) ? 60 : 100;
      for (int c = 0; c < 50; c++) begin
        tick();
        r = $urandom_range(0, 99);
        fetch_ir  = (r < 15);
        fetch_tr  = (r >= 10 && r < 25);
        jump_en   = ($urandom_range(0, 99) < 8);
        jump_addr = 8'($urandom);
        mem_ack   = ($urandom_range(0, 99) < ack_pct);
        if ($urandom_range(0, 999) < 3) begin
          #2 rst = 1'b1;
          #1 rst = 1'b0;
        end
      end
    end
    tick();
    fetch_ir = 1'b0; fetch_tr = 1'b0; jump_en = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
